mips_run_ctrl: RTL
==================

# mips_run_ctrl

Run/halt/single-step controller for the 8-bit single-cycle MIPS core. It gates the core's progress with a per-cycle enable, which the core's PC, register-file and data-memory writes qualify. A host issues commands over a valid/ready interface. The block provides an optional PC breakpoint, a one-cycle soft reset pulse and a retired-instruction counter.

## Interface
Parameters:
- PC_W, 4: width of the PC compare and breakpoint register
- CNT_W, 8: width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command strobe
- cmd_op  in  3  command: 000 NOP, 001 HALT, 010 RUN, 011 STEP, 100 SET_BP, 101 CLR_BP, 110 CLR_CNT, 111 SOFT_RST
- cmd_data  in  PC_W  breakpoint address for SET_BP; ignored otherwise
- cmd_ready  out  1  command accept; a command is taken at an edge where cmd_valid && cmd_ready
- pc  in  PC_W  current PC of the core, i.e. the address of the instruction being executed this cycle
- cpu_en  out  1  core advances one instruction at the edge ending a cycle where this is 1
- cpu_rst  out  1  registered one-cycle soft-reset pulse to the core
- state  out  2  00 HALT, 01 RUN, 10 STEP, 11 BRK
- halted  out  1  state is HALT or BRK
- retired  out  CNT_W  count of cycles with cpu_en=1

## Operation
- **Reset values.** state=HALT, cpu_en=0, cpu_rst=0, cmd_ready=1, retired=0, bp_valid=0, bp_addr=0, first=0.
- **cpu_en (combinational).** cpu_en = (state==STEP) || (state==RUN && !bp_hit).
- **Breakpoint hit.** bp_hit = bp_valid && pc==bp_addr && state==RUN && !first.
- **first flag.** first is set on every transition into RUN and cleared after one RUN cycle. This lets a RUN issued from a breakpoint PC execute that instruction.
- **cmd_ready.** cmd_ready = (state != STEP).
- **HALT and BRK states.**
  - RUN → RUN.
  - STEP → STEP.
  - HALT → HALT; in BRK, HALT → HALT (clears the BRK status).
  - SET_BP: bp_addr=cmd_data, bp_valid=1.
  - CLR_BP: bp_valid=0.
  - CLR_CNT: retired=0.
  - NOP: no effect.
- **RUN state.**
  - HALT → HALT; the current cycle's cpu_en is unaffected.
  - RUN and STEP are accepted and have no effect.
  - bp_hit → BRK with cpu_en=0, so the instruction at bp_addr is not executed.
  - bp_hit together with an accepted HALT → BRK (break wins).
- **STEP state.** Lasts exactly one cycle with cpu_en=1, then → HALT. Breakpoints are ignored in STEP.
- **SOFT_RST.** Accepted in any state with cmd_ready=1. Effects:
  - cpu_rst=1 for exactly the next cycle;
  - state → HALT;
  - retired → 0;
  - breakpoint registers are kept.
- **retired counter.** retired += 1 at each edge where cpu_en=1. It wraps from 2^CNT_W−1 to 0. CLR_CNT or SOFT_RST in the same cycle as an increment → 0 (clear wins).
- **Asynchronous reset mid-operation.** Returns every register to its reset value immediately; any in-flight STEP is abandoned.

## Timing
- A command accepted at edge k takes effect in the state output and cpu_en from cycle k+1.
- STEP accepted at edge k:
  - cycle k+1: state=STEP, cpu_en=1, cmd_ready=0;
  - from edge k+2: state=HALT, retired incremented by 1.
- RUN accepted at edge k: cpu_en=1 from cycle k+1; one instruction retires per cycle.
- Breakpoint stop is zero-latency. cpu_en drops in the same cycle pc equals bp_addr, and state=BRK from the next cycle.
- SOFT_RST accepted at edge k: cpu_rst=1 during cycle k+1 only, and cpu_en=0 from cycle k+1.

## Configuration
- **RUN_CTRL_BP_EN defined.** Breakpoint registers and compare are present as described above.
- **RUN_CTRL_BP_EN undefined.**
  - No breakpoint registers; bp_hit is constant 0 and BRK is unreachable.
  - SET_BP and CLR_BP are accepted as NOPs.
  - Other behaviour is unchanged.

## Test plan
- **Reset.** Reset, then idle 5 cycles → state=00, halted=1, cpu_en=0, retired=0, cmd_ready=1.
- **Single step.** STEP three times, each after cmd_ready returns → exactly three single-cycle cpu_en pulses, retired=3, cmd_ready=0 only during the STEP cycles.
- **Breakpoint.**
  - Stimulus: SET_BP data=5, then RUN, with pc modelled by a counter from 0.
  - cpu_en is 1 for pc 0–4 and 0 at pc=5; state=11; retired=5.
  - A following RUN executes pc=5 and continues.
- **Simultaneous HALT and hit.** HALT issued in RUN in the same cycle as a breakpoint hit → state=BRK. RUN then HALT without a breakpoint → state=HALT one cycle after accept.
- **Counter wrap and clear.** CNT_W=8, run 256 cycles → retired wraps to 0. CLR_CNT during RUN → retired=0 on the next cycle (clear wins over increment).
- **Soft and async reset.** SOFT_RST during RUN → cpu_rst high for one cycle, state=HALT, retired=0, bp_valid retained. Assert rst_n low mid-STEP → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run/halt/single-step controller for the 8-bit MIPS core
// Optional PC breakpoint is built when RUN_CTRL_BP_EN is defined.
module mips_run_ctrl #(
    parameter int PC_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [PC_W-1:0]  cmd_data,
    output logic             cmd_ready,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BRK  = 2'b11
    } state_e;

    localparam logic [2:0] OP_HALT     = 3'b001;
    localparam logic [2:0] OP_RUN      = 3'b010;
    localparam logic [2:0] OP_STEP     = 3'b011;
    localparam logic [2:0] OP_CLR_CNT  = 3'b110;
    localparam logic [2:0] OP_SOFT_RST = 3'b111;

    state_e           state_q, state_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             cmd_acc;
    logic             bp_hit;

    assign cmd_ready = (state_q != ST_STEP);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign cpu_en    = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_hit);
    assign cpu_rst   = cpu_rst_q;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT) || (state_q == ST_BRK);
    assign retired   = retired_q;

`ifdef RUN_CTRL_BP_EN
    localparam logic [2:0] OP_SET_BP = 3'b100;
    localparam logic [2:0] OP_CLR_BP = 3'b101;

    logic            bp_valid_q, bp_valid_d;
    logic [PC_W-1:0] bp_addr_q, bp_addr_d;
    logic            first_q, first_d;

    // first masks the compare for the opening RUN cycle so a resume from BRK executes bp_addr
    assign bp_hit = bp_valid_q && (pc == bp_addr_q) && (state_q == ST_RUN) && !first_q;

    always_comb begin
        bp_valid_d = bp_valid_q;
        bp_addr_d  = bp_addr_q;
        if (cmd_acc && (cmd_op == OP_SET_BP)) begin
            bp_valid_d = 1'b1;
            bp_addr_d  = cmd_data;
        end else if (cmd_acc && (cmd_op == OP_CLR_BP)) begin
            bp_valid_d = 1'b0;
        end
        first_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_valid_q <= 1'b0;
            bp_addr_q  <= '0;
            first_q    <= 1'b0;
        end else begin
            bp_valid_q <= bp_valid_d;
            bp_addr_q  <= bp_addr_d;
            first_q    <= first_d;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{pc, cmd_data};
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cpu_rst_d = 1'b0;
        retired_d = cpu_en ? (retired_q + CNT_W'(1)) : retired_q;
        if (cmd_acc && (cmd_op == OP_CLR_CNT)) begin
            retired_d = '0;
        end
        case (state_q)
            ST_HALT, ST_BRK: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN:  state_d = ST_RUN;
                        OP_STEP: state_d = ST_STEP;
                        OP_HALT: state_d = ST_HALT;
                        default: state_d = state_q;
                    endcase
                end
            end
            ST_RUN: begin
                // a breakpoint hit outranks a HALT accepted in the same cycle
                if (bp_hit) begin
                    state_d = ST_BRK;
                end else if (cmd_acc && (cmd_op == OP_HALT)) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        if (cmd_acc && (cmd_op == OP_SOFT_RST)) begin
            state_d   = ST_HALT;
            cpu_rst_d = 1'b1;
            retired_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HALT;
            cpu_rst_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= cpu_rst_d;
            retired_q <= retired_d;
        end
    end
endmodule
